// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring-divide step per clock on operand
// magnitudes, followed by a single sign-fixup cycle that commits HI/LO.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             rd_hilo_i,
   input  logic             wr_hi_i,
   input  logic             wr_lo_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Multiply: {partial product high, multiplier/product low}.
   // Divide:   {partial remainder, dividend shifting into quotient}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q, m_d;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
   logic [WIDTH-1:0]   quo, rem, div_lo, div_hi;

   // Operand conditioning and one datapath step for each operation.
   always_comb begin
      a_neg    = ~op_i[0] & a_i[WIDTH-1];
      b_neg    = ~op_i[0] & b_i[WIDTH-1];
      a_mag    = a_neg ? -a_i : a_i;
      b_mag    = b_neg ? -b_i : b_i;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, m_q};
      div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      // Sign flags are only set for signed ops, so no op check is needed here.
      prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo      = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      // Divide by zero leaves remainder = |a|; negating by sa restores a as issued.
      div_lo   = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
      div_hi   = sa_q ? -rem : rem;
   end

   // Next-state: issue, iterate, commit, and MTHI/MTLO when idle.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bz_d    = bz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               op_d    = op_i;
               sa_d    = a_neg;
               sb_d    = b_neg;
               bz_d    = op_i[1] & (b_i == '0);
               cnt_d   = '0;
               if (op_i[1]) begin
                  acc_d = {{WIDTH{1'b0}}, a_mag};
                  m_d   = b_mag;
               end else begin
                  acc_d = {{WIDTH{1'b0}}, b_mag};
                  m_d   = a_mag;
               end
            end else begin
               if (wr_hi_i) hi_d = wr_data_i;
               if (wr_lo_i) lo_d = wr_data_i;
            end
         end
         S_RUN: begin
            acc_d = op_q[1] ? div_nxt : mul_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (op_q[1]) begin
               hi_d = div_hi;
               lo_d = div_lo;
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (state_q != S_IDLE);
   assign stall_o = busy_o & (rd_hilo_i | start_i | wr_hi_i | wr_lo_i);
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule
